// File: rtl/pow3_sink_pkg.sv
// Shared types, constants and the power-of-3 step function for pow3_stream_sink.
package pow3_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAULT = 2'd2
  } chk_state_t;

  localparam int unsigned POW3_MUL  = 3;
  localparam int unsigned POW3_SEED = 3;

  // Next term of the sequence: 3*x as (x << 1) + x, truncated to width bits.
  function automatic logic [63:0] next_pow3(input logic [63:0] x, input int unsigned width);
    logic [63:0] mask;
    logic [63:0] y;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    y    = (x << (POW3_MUL >> 1)) + x;
    return y & mask;
  endfunction

endpackage

// File: rtl/pow3_stream_sink_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered read data and flags; no write-to-read bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr_c;
  logic             do_rd_c;
  logic [CW-1:0]    count_nxt_c;

  // Qualify requests against the registered flags and form the next occupancy.
  always_comb begin
    do_wr_c     = wr_en && !full;
    do_rd_c     = rd_en && !empty;
    count_nxt_c = count + CW'(do_wr_c) - CW'(do_rd_c);
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_wr_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, flags and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_wr_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= do_rd_c;
      count    <= count_nxt_c;
      empty    <= (count_nxt_c == '0);
      full     <= (count_nxt_c == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/pow3_stream_sink.sv
// AXI4-Stream sink for the power-of-3 generator: buffers beats in a FIFO and
// optionally checks them against 3, 9, 27, ... (build option POW3_SINK_CHECK_EN).
module pow3_stream_sink
  import pow3_sink_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_aresetn,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  input  logic                   rd_en,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  input  logic                   chk_clear,
  output logic [31:0]            beat_count,
  output logic                   err_flag,
  output logic [DATA_SIZE-1:0]   err_expected,
  output logic [DATA_SIZE-1:0]   err_actual
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic [CW-1:0] count_nxt_c;
  logic          tready_d;
  logic          unused_c;

  // Side-band fields carry no information for this sink.
  assign unused_c = ^{s00_axis_tstrb, s00_axis_tlast};

  // Handshake qualification and the occupancy the FIFO will hold after this edge.
  always_comb begin
    accept_c    = s00_axis_tvalid && s00_axis_tready;
    push_c      = accept_c && !fifo_full;
    pop_c       = rd_en && !fifo_empty;
    count_nxt_c = fifo_count + CW'(push_c) - CW'(pop_c);
    tready_d    = (count_nxt_c <= CW'(DEPTH - 2));
  end

  // tready keeps one spare slot for a beat launched just before tready drops.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      s00_axis_tready <= 1'b0;
    end else begin
      s00_axis_tready <= tready_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (s00_axis_aclk),
    .rst_n    (s00_axis_aresetn),
    .wr_en    (accept_c),
    .wr_data  (s00_axis_tdata),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifdef POW3_SINK_CHECK_EN

  chk_state_t           state_q;
  chk_state_t           state_d;
  logic [DATA_SIZE-1:0] exp_q;
  logic [DATA_SIZE-1:0] exp_d;
  logic [31:0]          beat_count_d;
  logic                 err_flag_d;
  logic [DATA_SIZE-1:0] err_expected_d;
  logic [DATA_SIZE-1:0] err_actual_d;

  // Checker next state: clear wins over a coincident beat; FAULT freezes compares.
  always_comb begin
    state_d        = state_q;
    exp_d          = exp_q;
    beat_count_d   = beat_count;
    err_flag_d     = err_flag;
    err_expected_d = err_expected;
    err_actual_d   = err_actual;
    if (chk_clear) begin
      state_d        = IDLE;
      exp_d          = DATA_SIZE'(POW3_SEED);
      beat_count_d   = '0;
      err_flag_d     = 1'b0;
      err_expected_d = '0;
      err_actual_d   = '0;
    end else if (accept_c) begin
      beat_count_d = (beat_count == '1) ? beat_count : beat_count + 32'd1;
      case (state_q)
        IDLE, CHECK: begin
          if (s00_axis_tdata == exp_q) begin
            state_d = CHECK;
            exp_d   = DATA_SIZE'(next_pow3(64'(exp_q), DATA_SIZE));
          end else begin
            state_d        = FAULT;
            err_flag_d     = 1'b1;
            err_expected_d = exp_q;
            err_actual_d   = s00_axis_tdata;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Checker state register.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q      <= IDLE;
      exp_q        <= DATA_SIZE'(POW3_SEED);
      beat_count   <= '0;
      err_flag     <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      beat_count   <= beat_count_d;
      err_flag     <= err_flag_d;
      err_expected <= err_expected_d;
      err_actual   <= err_actual_d;
    end
  end

`else

  logic [31:0] beat_count_d;

  // Plain saturating count of accepted beats, restarted by chk_clear.
  always_comb begin
    beat_count_d = beat_count;
    if (chk_clear) begin
      beat_count_d = '0;
    end else if (accept_c) begin
      beat_count_d = (beat_count == '1) ? beat_count : beat_count + 32'd1;
    end
  end

  // Beat counter register.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      beat_count <= '0;
    end else begin
      beat_count <= beat_count_d;
    end
  end

  assign err_flag     = 1'b0;
  assign err_expected = '0;
  assign err_actual   = '0;

`endif

endmodule

// File: tb/tb_pow3_stream_sink.sv
// Self-checking bench for pow3_stream_sink against a queue-based reference model.
module tb_pow3_stream_sink;

  localparam int DW  = 32;
  localparam int DEP = 8;
`ifdef POW3_SINK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [3:0]    tstrb = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic          chk_clear = 1'b0;
  logic [31:0]   beat_count;
  logic          err_flag;
  logic [DW-1:0] err_expected;
  logic [DW-1:0] err_actual;

  always #5 clk = ~clk;

  pow3_stream_sink #(.DATA_SIZE(DW), .DEPTH(DEP)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (tdata),
    .s00_axis_tstrb   (tstrb),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tlast   (tlast),
    .s00_axis_tready  (tready),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .chk_clear        (chk_clear),
    .beat_count       (beat_count),
    .err_flag         (err_flag),
    .err_expected     (err_expected),
    .err_actual       (err_actual)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit [31:0] m_q[$];
  bit        m_tready;
  bit        m_rd_valid;
  bit [31:0] m_rd_data;
  bit [31:0] m_bc;
  bit [31:0] m_exp;
  bit        m_err;
  bit [31:0] m_eexp;
  bit [31:0] m_eact;

  task automatic model_reset();
    m_q.delete();
    m_tready   = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
    m_bc       = '0;
    m_exp      = 32'd3;
    m_err      = 1'b0;
    m_eexp     = '0;
    m_eact     = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return 1 time unit after it.
  task automatic cycle(input bit v, input bit [31:0] d, input bit rd, input bit clr);
    bit acc;
    bit pop;
    tvalid    = v;
    tdata     = d;
    rd_en     = rd;
    chk_clear = clr;
    tstrb     = 4'($urandom);
    tlast     = 1'b1;
    acc = v && m_tready;
    pop = rd && (m_q.size() != 0);
    if (pop) begin
      m_rd_data  = m_q.pop_front();
      m_rd_valid = 1'b1;
    end else begin
      m_rd_valid = 1'b0;
    end
    if (acc) m_q.push_back(d);
    if (clr) begin
      m_bc = '0; m_err = 1'b0; m_eexp = '0; m_eact = '0; m_exp = 32'd3;
    end else if (acc) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (!m_err) begin
        if (d == m_exp) m_exp = 32'(64'(m_exp) * 3);
        else begin m_err = 1'b1; m_eexp = m_exp; m_eact = d; end
      end
    end
    m_tready = (DEP - m_q.size()) >= 2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid = 1'b0; rd_en = 1'b0; chk_clear = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", tready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", fifo_empty, fifo_full); end
    checks++; if (beat_count !== '0 || err_flag !== 1'b0) begin errors++; $display("FAIL reset_chk: got bc=%0d err=%b expected 0/0", beat_count, err_flag); end
    checks++; if (err_expected !== '0 || err_actual !== '0) begin errors++; $display("FAIL reset_caps: got %0h/%0h expected 0/0", err_expected, err_actual); end
    rst_n = 1'b1;
    #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL tready_before_edge: got %b expected 0", tready); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL tready_first_edge: got %b expected 1", tready); end
  endtask

  task automatic test_basic();
    bit [31:0] vals[4] = '{32'd3, 32'd9, 32'd27, 32'd81};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0, 1'b0);
      checks++; if (tready !== m_tready) begin errors++; $display("FAIL basic_tready[%0d]: got %b expected %b", i, tready, m_tready); end
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL basic_tready_end: got %b expected 1", tready); end
    checks++; if (beat_count !== 32'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", beat_count); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err_flag); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %b expected 0", fifo_empty); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin errors++; $display("FAIL basic_drain[%0d]: got v=%b d=%0d expected 1/%0d", i, rd_valid, rd_data, vals[i]); end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_read: got v=%b empty=%b expected 0/1", rd_valid, fifo_empty); end
  endtask

  task automatic test_wrap();
    bit [31:0] p = 32'd3;
    int fed = 0;
    int popped = 0;
    do_reset();
    for (int c = 0; c < 400 && popped < 21; c++) begin
      bit v;
      bit acc;
      v = (fed < 21) && ($urandom_range(3) != 0);
      acc = v && m_tready;
      cycle(v, p, (fed >= 21) || ($urandom_range(1) == 1), 1'b0);
      if (acc) begin fed++; p = 32'(64'(p) * 3); end
      if (rd_valid === 1'b1) begin
        popped++;
        checks++; if (rd_data !== m_rd_data) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", popped, rd_data, m_rd_data); end
        if (popped == 20) begin
          checks++; if (rd_data !== 32'd3486784401) begin errors++; $display("FAIL wrap_beat20: got %0d expected 3486784401", rd_data); end
        end
        if (popped == 21) begin
          checks++; if (rd_data !== 32'd1870418611) begin errors++; $display("FAIL wrap_beat21: got %0d expected 1870418611", rd_data); end
        end
      end
    end
    checks++; if (popped != 21) begin errors++; $display("FAIL wrap_pops: got %0d expected 21", popped); end
    checks++; if (beat_count !== 32'd21 || err_flag !== 1'b0) begin errors++; $display("FAIL wrap_status: got bc=%0d err=%b expected 21/0", beat_count, err_flag); end
  endtask

  task automatic test_fault();
    bit [31:0] vals[4] = '{32'd3, 32'd9, 32'd28, 32'd81};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0, 1'b0);
      if (i == 2) begin
        checks++; if (err_flag !== CHK) begin errors++; $display("FAIL fault_flag_beat3: got %b expected %b", err_flag, CHK); end
      end
    end
    checks++; if (err_expected !== (CHK ? 32'd27 : 32'd0)) begin errors++; $display("FAIL fault_expected: got %0d expected %0d", err_expected, CHK ? 27 : 0); end
    checks++; if (err_actual !== (CHK ? 32'd28 : 32'd0)) begin errors++; $display("FAIL fault_actual: got %0d expected %0d", err_actual, CHK ? 28 : 0); end
    checks++; if (beat_count !== 32'd4 || err_flag !== CHK) begin errors++; $display("FAIL fault_status: got bc=%0d err=%b expected 4/%b", beat_count, err_flag, CHK); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin errors++; $display("FAIL fault_drain[%0d]: got v=%b d=%0d expected 1/%0d", i, rd_valid, rd_data, vals[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit [31:0] p = 32'd3;
    bit [31:0] q = 32'd3;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bit acc;
      acc = m_tready;
      cycle(1'b1, p, 1'b0, 1'b0);
      if (acc) p = 32'(64'(p) * 3);
      checks++; if (tready !== m_tready) begin errors++; $display("FAIL bp_tready[%0d]: got %b expected %b", i, tready, m_tready); end
      checks++; if (fifo_full !== (m_q.size() == DEP)) begin errors++; $display("FAIL bp_full[%0d]: got %b expected %b", i, fifo_full, m_q.size() == DEP); end
    end
    for (int i = 0; i < DEP + 2; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      if (rd_valid === 1'b1) begin
        pops++;
        checks++; if (rd_data !== q) begin errors++; $display("FAIL bp_drain[%0d]: got %0d expected %0d", pops, rd_data, q); end
        q = 32'(64'(q) * 3);
      end
    end
    checks++; if (pops != DEP - 1) begin errors++; $display("FAIL bp_count: got %0d expected %0d", pops, DEP - 1); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_clear();
    bit [31:0] vals[5] = '{32'd3, 32'd9, 32'd28, 32'd5, 32'd3};
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, vals[i], 1'b0, 1'b0);
    checks++; if (err_flag !== CHK) begin errors++; $display("FAIL clear_pre_flag: got %b expected %b", err_flag, CHK); end
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    checks++; if (err_flag !== 1'b0 || beat_count !== 32'd0) begin errors++; $display("FAIL clear_status: got err=%b bc=%0d expected 0/0", err_flag, beat_count); end
    checks++; if (err_expected !== '0 || err_actual !== '0) begin errors++; $display("FAIL clear_caps: got %0d/%0d expected 0/0", err_expected, err_actual); end
    cycle(1'b1, 32'd3, 1'b0, 1'b0);
    checks++; if (err_flag !== 1'b0 || beat_count !== 32'd1) begin errors++; $display("FAIL clear_after: got err=%b bc=%0d expected 0/1", err_flag, beat_count); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin errors++; $display("FAIL clear_drain[%0d]: got v=%b d=%0d expected 1/%0d", i, rd_valid, rd_data, vals[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit v;
      bit rd;
      bit clr;
      bit [31:0] d;
      v   = ($urandom_range(3) != 0);
      rd  = ((c / 100) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      clr = ($urandom_range(49) == 0);
      d   = ($urandom_range(19) == 0) ? 32'($urandom) : m_exp;
      cycle(v, d, rd, clr);
      checks++; if (tready !== m_tready) begin errors++; $display("FAIL rnd_tready@%0d: got %b expected %b", c, tready, m_tready); end
      checks++; if (rd_valid !== m_rd_valid) begin errors++; $display("FAIL rnd_rd_valid@%0d: got %b expected %b", c, rd_valid, m_rd_valid); end
      checks++; if (rd_data !== m_rd_data) begin errors++; $display("FAIL rnd_rd_data@%0d: got %0h expected %0h", c, rd_data, m_rd_data); end
      checks++; if (fifo_empty !== (m_q.size() == 0) || fifo_full !== (m_q.size() == DEP)) begin errors++; $display("FAIL rnd_flags@%0d: got e=%b f=%b expected size %0d", c, fifo_empty, fifo_full, m_q.size()); end
      checks++; if (beat_count !== m_bc) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, beat_count, m_bc); end
      checks++; if (err_flag !== (CHK & m_err)) begin errors++; $display("FAIL rnd_err@%0d: got %b expected %b", c, err_flag, CHK & m_err); end
      checks++; if (err_expected !== (CHK ? m_eexp : 32'd0) || err_actual !== (CHK ? m_eact : 32'd0)) begin errors++; $display("FAIL rnd_caps@%0d: got %0h/%0h expected %0h/%0h", c, err_expected, err_actual, CHK ? m_eexp : 0, CHK ? m_eact : 0); end
    end
  endtask

  task automatic test_async_reset();
    bit [31:0] p = 32'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, p, 1'b0, 1'b0);
      p = 32'(64'(p) * 3);
    end
    checks++; if (fifo_empty !== 1'b0 || beat_count !== 32'd5) begin errors++; $display("FAIL arst_pre: got empty=%b bc=%0d expected 0/5", fifo_empty, beat_count); end
    tvalid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (tready !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL arst_flags: got rdy=%b e=%b f=%b expected 0/1/0", tready, fifo_empty, fifo_full); end
    checks++; if (beat_count !== '0 || err_flag !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL arst_outs: got bc=%0d err=%b v=%b d=%0h expected zeros", beat_count, err_flag, rd_valid, rd_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL arst_read: got v=%b e=%b expected 0/1", rd_valid, fifo_empty); end
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL arst_tready: got %b expected 1", tready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_fault();
    test_backpressure();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
